id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the IF stage and the IF/ID register.
- Consumes PC_plus_four and instruction from the IF/ID register.
- Contains the 32x32 register file, main/ALU control decode, early branch/jump resolution and load-use/branch hazard detection.
- Drives PCSrc/PC_branch/Jump/PC_Jump back to IF, and holds the ID/EX pipeline register feeding EX.

---
 rtl/id_stage.sv | 210 +++++++++++++++++++++
 tb/tb_id_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register file, control decode, early branch/jump
// resolution, load-use and branch hazard detection, and the ID/EX pipeline register.
module id_stage #(
    parameter int          REG_COUNT   = 32,
    parameter logic [3:0]  RESET_PC_HI = 4'b0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] PC_plus_four_in,
    input  logic [31:0] instruction_in,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    input  logic        mem_RegWrite,
    input  logic [4:0]  mem_write_reg,
    output logic        stall,
    output logic        flush,
    output logic        PCSrc,
    output logic [31:0] PC_branch,
    output logic        Jump,
    output logic [31:0] PC_Jump,
    output logic        ex_RegWrite,
    output logic        ex_MemtoReg,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_ALUSrc,
    output logic [2:0]  ex_ALUControl,
    output logic [31:0] ex_read_data_1,
    output logic [31:0] ex_read_data_2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_write_reg
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [31:0] regs [REG_COUNT];

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_active;

    logic        dec_reg_write;
    logic        dec_mem_to_reg;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_alu_src;
    logic [2:0]  dec_alu_control;
    logic [4:0]  dec_write_reg;
    logic        uses_rs;
    logic        uses_rt;
    logic        is_beq;
    logic        load_use_stall;
    logic        branch_stall;

    assign op    = instruction_in[31:26];
    assign rs    = instruction_in[25:21];
    assign rt    = instruction_in[20:16];
    assign rd    = instruction_in[15:11];
    assign funct = instruction_in[5:0];
    assign imm   = {{16{instruction_in[15]}}, instruction_in[15:0]};

    assign wb_active = wb_RegWrite && (wb_write_reg != 5'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_active) begin
            regs[wb_write_reg] <= wb_write_data;
        end
    end

    // Write-through: a value retiring this cycle is visible to the instruction in ID.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs != 5'd0) begin
            rd1 = (wb_active && wb_write_reg == rs) ? wb_write_data : regs[rs];
        end
        if (rt != 5'd0) begin
            rd2 = (wb_active && wb_write_reg == rt) ? wb_write_data : regs[rt];
        end
    end

    always_comb begin
        dec_reg_write   = 1'b0;
        dec_mem_to_reg  = 1'b0;
        dec_mem_read    = 1'b0;
        dec_mem_write   = 1'b0;
        dec_alu_src     = 1'b0;
        dec_alu_control = 3'b000;
        dec_write_reg   = 5'd0;
        uses_rs         = 1'b0;
        uses_rt         = 1'b0;
        is_beq          = 1'b0;
        case (op)
            OP_RTYPE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                case (funct)
                    6'b100000: dec_alu_control = 3'b010;
                    6'b100010: dec_alu_control = 3'b110;
                    6'b100100: dec_alu_control = 3'b000;
                    6'b100101: dec_alu_control = 3'b001;
                    6'b101010: dec_alu_control = 3'b111;
                    default:   dec_alu_control = 3'b000;
                endcase
                if (funct == 6'b100000 || funct == 6'b100010 || funct == 6'b100100 ||
                    funct == 6'b100101 || funct == 6'b101010) begin
                    dec_reg_write = 1'b1;
                    dec_write_reg = rd;
                end
            end
            OP_LW: begin
                uses_rs         = 1'b1;
                dec_reg_write   = 1'b1;
                dec_mem_to_reg  = 1'b1;
                dec_mem_read    = 1'b1;
                dec_alu_src     = 1'b1;
                dec_alu_control = 3'b010;
                dec_write_reg   = rt;
            end
            OP_SW: begin
                uses_rs         = 1'b1;
                uses_rt         = 1'b1;
                dec_mem_write   = 1'b1;
                dec_alu_src     = 1'b1;
                dec_alu_control = 3'b010;
            end
            OP_ADDI: begin
                uses_rs         = 1'b1;
                dec_reg_write   = 1'b1;
                dec_alu_src     = 1'b1;
                dec_alu_control = 3'b010;
                dec_write_reg   = rt;
            end
            OP_BEQ: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                is_beq  = 1'b1;
            end
            default: ;
        endcase
    end

    // A beq resolves in ID, so it must wait for producers still in EX or MEM.
    always_comb begin
        load_use_stall = ex_MemRead && (ex_write_reg != 5'd0) &&
                         ((uses_rs && rs == ex_write_reg) || (uses_rt && rt == ex_write_reg));
        branch_stall   = is_beq &&
                         ((uses_rs && rs != 5'd0 &&
                           ((ex_RegWrite && rs == ex_write_reg) || (mem_RegWrite && rs == mem_write_reg))) ||
                          (uses_rt && rt != 5'd0 &&
                           ((ex_RegWrite && rt == ex_write_reg) || (mem_RegWrite && rt == mem_write_reg))));
        stall          = load_use_stall || branch_stall;
    end

    assign PC_branch = PC_plus_four_in + {imm[29:0], 2'b00};
    assign PCSrc     = is_beq && (rd1 == rd2) && !stall;
    assign Jump      = (op == OP_J);
    assign PC_Jump   = {PC_plus_four_in[31:28], instruction_in[25:0], 2'b00};
    assign flush     = PCSrc || Jump;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n || stall) begin
            if (!reset_n || stall) begin
                ex_RegWrite    <= 1'b0;
                ex_MemtoReg    <= 1'b0;
                ex_MemRead     <= 1'b0;
                ex_MemWrite    <= 1'b0;
                ex_ALUSrc      <= 1'b0;
                ex_ALUControl  <= 3'b000;
                ex_read_data_1 <= '0;
                ex_read_data_2 <= '0;
                ex_imm         <= '0;
                ex_rs          <= '0;
                ex_rt          <= '0;
                ex_write_reg   <= '0;
            end
        end else begin
            ex_RegWrite    <= dec_reg_write;
            ex_MemtoReg    <= dec_mem_to_reg;
            ex_MemRead     <= dec_mem_read;
            ex_MemWrite    <= dec_mem_write;
            ex_ALUSrc      <= dec_alu_src;
            ex_ALUControl  <= dec_alu_control;
            ex_read_data_1 <= rd1;
            ex_read_data_2 <= rd2;
            ex_imm         <= imm;
            ex_rs          <= rs;
            ex_rt          <= rt;
            ex_write_reg   <= dec_write_reg;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized pipeline traffic
// checked against a behavioural model of the decode stage.
module tb_id_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] PC_plus_four_in;
    logic [31:0] instruction_in;
    logic        wb_RegWrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        mem_RegWrite;
    logic [4:0]  mem_write_reg;
    logic        stall, flush, PCSrc, Jump;
    logic [31:0] PC_branch, PC_Jump;
    logic        ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc;
    logic [2:0]  ex_ALUControl;
    logic [31:0] ex_read_data_1, ex_read_data_2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_write_reg;

    id_stage dut (
        .clock(clock), .reset_n(reset_n),
        .PC_plus_four_in(PC_plus_four_in), .instruction_in(instruction_in),
        .wb_RegWrite(wb_RegWrite), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .mem_RegWrite(mem_RegWrite), .mem_write_reg(mem_write_reg),
        .stall(stall), .flush(flush), .PCSrc(PCSrc), .PC_branch(PC_branch),
        .Jump(Jump), .PC_Jump(PC_Jump),
        .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_ALUControl(ex_ALUControl),
        .ex_read_data_1(ex_read_data_1), .ex_read_data_2(ex_read_data_2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Architectural view of the stage: register values and the contents of ID/EX.
    logic [31:0] m_regs [32];
    logic        m_rw, m_mtr, m_mr, m_mw, m_as;
    logic [2:0]  m_alu;
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_wr;

    logic        obs_stall, obs_flush, obs_pcsrc, obs_jump;
    logic [31:0] obs_pc_branch, obs_pc_jump;
    logic        exp_stall_last, exp_flush_last;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        {m_rw, m_mtr, m_mr, m_mw, m_as} = '0;
        m_alu = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_wr = '0;
    endtask

    task automatic checkEx(input string tag);
        checkOutput({tag, ".RegWrite"}, 32'(ex_RegWrite), 32'(m_rw));
        checkOutput({tag, ".MemtoReg"}, 32'(ex_MemtoReg), 32'(m_mtr));
        checkOutput({tag, ".MemRead"}, 32'(ex_MemRead), 32'(m_mr));
        checkOutput({tag, ".MemWrite"}, 32'(ex_MemWrite), 32'(m_mw));
        checkOutput({tag, ".ALUSrc"}, 32'(ex_ALUSrc), 32'(m_as));
        checkOutput({tag, ".ALUControl"}, 32'(ex_ALUControl), 32'(m_alu));
        checkOutput({tag, ".rd1"}, ex_read_data_1, m_rd1);
        checkOutput({tag, ".rd2"}, ex_read_data_2, m_rd2);
        checkOutput({tag, ".imm"}, ex_imm, m_imm);
        checkOutput({tag, ".rs"}, 32'(ex_rs), 32'(m_rs));
        checkOutput({tag, ".rt"}, 32'(ex_rt), 32'(m_rt));
        checkOutput({tag, ".write_reg"}, 32'(ex_write_reg), 32'(m_wr));
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (wb_RegWrite && wb_write_reg == idx) return wb_write_data;
        return m_regs[idx];
    endfunction

    // One ID cycle: drive at negedge, check combinational results, clock, check ID/EX.
    task automatic applyStimulus(input logic [31:0] pc4, input logic [31:0] instr,
                                 input logic wb_en, input logic [4:0] wb_reg, input logic [31:0] wb_data,
                                 input logic mem_en, input logic [4:0] mem_reg);
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd, wr;
        logic rw, mtr, mr, mw, as, use_s, use_t, beq, legal_r;
        logic [2:0] alu;
        logic [31:0] imm, a, b, exp_branch;
        logic lu, bs, st, pcs, jmp;
        @(negedge clock);
        PC_plus_four_in = pc4; instruction_in = instr;
        wb_RegWrite = wb_en; wb_write_reg = wb_reg; wb_write_data = wb_data;
        mem_RegWrite = mem_en; mem_write_reg = mem_reg;
        #1;
        op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11]; fn = instr[5:0];
        imm = {{16{instr[15]}}, instr[15:0]};
        {rw, mtr, mr, mw, as, use_s, use_t, beq} = '0;
        alu = 3'd0; wr = 5'd0;
        legal_r = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
        if (op == 6'h00) begin
            use_s = 1; use_t = 1;
            if (legal_r) begin
                rw = 1; wr = rd;
                alu = (fn == 6'h20) ? 3'd2 : (fn == 6'h22) ? 3'd6 : (fn == 6'h24) ? 3'd0 :
                      (fn == 6'h25) ? 3'd1 : 3'd7;
            end
        end else if (op == 6'h23) begin
            use_s = 1; rw = 1; mtr = 1; mr = 1; as = 1; alu = 3'd2; wr = rt;
        end else if (op == 6'h2B) begin
            use_s = 1; use_t = 1; mw = 1; as = 1; alu = 3'd2;
        end else if (op == 6'h08) begin
            use_s = 1; rw = 1; as = 1; alu = 3'd2; wr = rt;
        end else if (op == 6'h04) begin
            use_s = 1; use_t = 1; beq = 1;
        end
        a = modelRead(rs);
        b = modelRead(rt);
        lu = m_mr && (m_wr != 0) && ((use_s && rs == m_wr) || (use_t && rt == m_wr));
        bs = beq && ((rs != 0 && ((m_rw && rs == m_wr) || (mem_en && rs == mem_reg))) ||
                     (rt != 0 && ((m_rw && rt == m_wr) || (mem_en && rt == mem_reg))));
        st = lu || bs;
        pcs = beq && (a == b) && !st;
        jmp = (op == 6'h02);
        exp_branch = pc4 + imm * 4;
        obs_stall = stall; obs_flush = flush; obs_pcsrc = PCSrc; obs_jump = Jump;
        obs_pc_branch = PC_branch; obs_pc_jump = PC_Jump;
        checkOutput("stall", 32'(stall), 32'(st));
        checkOutput("PCSrc", 32'(PCSrc), 32'(pcs));
        checkOutput("PC_branch", PC_branch, exp_branch);
        checkOutput("Jump", 32'(Jump), 32'(jmp));
        checkOutput("PC_Jump", PC_Jump, {pc4[31:28], instr[25:0], 2'b00});
        checkOutput("flush", 32'(flush), 32'(pcs || jmp));
        exp_stall_last = st; exp_flush_last = pcs || jmp;
        @(posedge clock);
        #1;
        if (wb_en && wb_reg != 0) m_regs[wb_reg] = wb_data;
        if (st) begin
            {m_rw, m_mtr, m_mr, m_mw, m_as} = '0;
            m_alu = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_wr = '0;
        end else begin
            {m_rw, m_mtr, m_mr, m_mw, m_as} = {rw, mtr, mr, mw, as};
            m_alu = alu; m_rd1 = a; m_rd2 = b; m_imm = imm; m_rs = rs; m_rt = rt; m_wr = wr;
        end
        checkEx("ex");
    endtask

    // Reset dropped between edges; ID/EX must clear without waiting for a clock.
    task automatic pulseReset();
        instruction_in = '0; wb_RegWrite = 0; mem_RegWrite = 0;
        #2 reset_n = 1'b0;
        #1;
        clearModel();
        checkEx("rst");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] randomInstr();
        logic [5:0] functs [5];
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 7))
            0, 1:    return {6'h00, rs, rt, rd, 5'd0, functs[$urandom_range(0, 4)]};
            2:       return {6'h23, rs, rt, imm};
            3:       return {6'h2B, rs, rt, imm};
            4:       return {6'h08, rs, rt, imm};
            5:       return {6'h04, rs, rt, imm};
            6:       return {6'h02, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] instr;
        reset_n = 1'b0;
        PC_plus_four_in = '0; instruction_in = '0;
        wb_RegWrite = 0; wb_write_reg = '0; wb_write_data = '0;
        mem_RegWrite = 0; mem_write_reg = '0;
        clearModel();
        exp_stall_last = 0; exp_flush_last = 0;
        #12;
        checkEx("init");
        @(negedge clock);
        reset_n = 1'b1;

        // Write-back bypass into an add, and writes to $0 ignored
        applyStimulus(32'h4, {6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20}, 1, 5'd3, 32'h1234, 0, 5'd0);
        checkOutput("byp_rd1", ex_read_data_1, 32'h1234);
        checkOutput("byp_rd2", ex_read_data_2, 32'h1234);
        checkOutput("byp_alu", 32'(ex_ALUControl), 32'd2);
        checkOutput("byp_wr", 32'(ex_write_reg), 32'd4);
        applyStimulus(32'h8, {6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20}, 1, 5'd0, 32'hFFFF, 0, 5'd0);
        checkOutput("r0_rd1", ex_read_data_1, 32'd0);

        // Load-use: lw $2,8($1) then sub $5,$2,$6
        applyStimulus(32'hC, {6'h23, 5'd1, 5'd2, 16'd8}, 0, 5'd0, 0, 0, 5'd0);
        applyStimulus(32'h10, {6'h00, 5'd2, 5'd6, 5'd5, 5'd0, 6'h22}, 0, 5'd0, 0, 0, 5'd0);
        checkOutput("lu_stall", 32'(obs_stall), 32'd1);
        checkOutput("lu_bubble", 32'(ex_RegWrite), 32'd0);
        applyStimulus(32'h10, {6'h00, 5'd2, 5'd6, 5'd5, 5'd0, 6'h22}, 0, 5'd0, 0, 0, 5'd0);
        checkOutput("lu_release", 32'(obs_stall), 32'd0);
        checkOutput("lu_sub_alu", 32'(ex_ALUControl), 32'd6);

        // Taken and not-taken beq
        applyStimulus(32'h0, 32'h0, 1, 5'd1, 32'd7, 0, 5'd0);
        applyStimulus(32'h0, 32'h0, 1, 5'd2, 32'd7, 0, 5'd0);
        applyStimulus(32'h10, {6'h04, 5'd1, 5'd2, 16'hFFFF}, 0, 5'd0, 0, 0, 5'd0);
        checkOutput("beq_taken", 32'(obs_pcsrc), 32'd1);
        checkOutput("beq_target", obs_pc_branch, 32'h0C);
        checkOutput("beq_flush", 32'(obs_flush), 32'd1);
        applyStimulus(32'h0, 32'h0, 1, 5'd2, 32'd8, 0, 5'd0);
        applyStimulus(32'h10, {6'h04, 5'd1, 5'd2, 16'hFFFF}, 0, 5'd0, 0, 0, 5'd0);
        checkOutput("beq_nt", 32'(obs_pcsrc), 32'd0);
        checkOutput("beq_nt_flush", 32'(obs_flush), 32'd0);

        // Branch stall behind addi $1,$0,5: EX match, then MEM match, then resolve
        applyStimulus(32'h0, 32'h0, 1, 5'd2, 32'd5, 0, 5'd0);
        applyStimulus(32'hFC, {6'h08, 5'd0, 5'd1, 16'd5}, 0, 5'd0, 0, 0, 5'd0);
        applyStimulus(32'h100, {6'h04, 5'd1, 5'd2, 16'd4}, 0, 5'd0, 0, 0, 5'd0);
        checkOutput("bs_ex", 32'(obs_stall), 32'd1);
        checkOutput("bs_ex_pcsrc", 32'(obs_pcsrc), 32'd0);
        applyStimulus(32'h100, {6'h04, 5'd1, 5'd2, 16'd4}, 0, 5'd0, 0, 1, 5'd1);
        checkOutput("bs_mem", 32'(obs_stall), 32'd1);
        applyStimulus(32'h100, {6'h04, 5'd1, 5'd2, 16'd4}, 1, 5'd1, 32'd5, 0, 5'd0);
        checkOutput("bs_done", 32'(obs_stall), 32'd0);
        checkOutput("bs_taken", 32'(obs_pcsrc), 32'd1);
        checkOutput("bs_target", obs_pc_branch, 32'h110);

        // Jump and illegal opcode
        applyStimulus(32'h20, {6'h02, 26'h10}, 0, 5'd0, 0, 0, 5'd0);
        checkOutput("j_jump", 32'(obs_jump), 32'd1);
        checkOutput("j_target", obs_pc_jump, 32'h40);
        checkOutput("j_flush", 32'(obs_flush), 32'd1);
        applyStimulus(32'h24, {6'h3F, 26'h3FFFFFF}, 0, 5'd0, 0, 0, 5'd0);
        checkOutput("ill_ctrl", 32'({ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc}), 32'd0);
        checkOutput("ill_alu", 32'(ex_ALUControl), 32'd0);

        // Randomized traffic; a stalled instruction is re-presented, a flushed slot becomes 0
        instr = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if (exp_stall_last) instr = instr;
            else if (exp_flush_last) instr = 32'h0;
            else instr = randomInstr();
            applyStimulus($urandom & 32'hFFFF_FFFC, instr, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)),
                          ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        end

        // Mid-run reset with $5 holding a nonzero value
        applyStimulus(32'h0, 32'h0, 1, 5'd5, 32'hABCD, 0, 5'd0);
        applyStimulus(32'h0, {6'h00, 5'd5, 5'd5, 5'd6, 5'd0, 6'h20}, 0, 5'd0, 0, 0, 5'd0);
        pulseReset();
        applyStimulus(32'h0, {6'h00, 5'd5, 5'd5, 5'd6, 5'd0, 6'h20}, 0, 5'd0, 0, 0, 5'd0);
        checkOutput("rst_r5", ex_read_data_1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
